// File: rtl/pulse_queue.sv
// Timed pulse FIFO: stamps each instruction with an absolute start time and fires it when `counter` arrives.
// Optional macro PULSE_LATE_DROP_EN: heads later than LATE_TOL cycles are discarded instead of fired.
module pulse_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LATE_TOL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pulse_inst_in,
  input  logic                     pulse_inst_in_valid,
  output logic                     pulse_inst_in_ready,
  input  logic                     flush,
  input  logic [31:0]              counter,
  output logic                     pulse_out_valid,
  output logic [1:0]               pulse_channel,
  output logic [5:0]               pulse_freq,
  output logic [5:0]               pulse_phase,
  output logic [5:0]               pulse_amp,
  output logic [31:0]              pulse_t_start,
  output logic                     pulse_late,
  output logic [15:0]              late_count,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

`ifdef PULSE_LATE_DROP_EN
  localparam bit LATE_DROP = 1'b1;
`else
  localparam bit LATE_DROP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  channel;
    logic [5:0]  freq;
    logic [5:0]  phase;
    logic [5:0]  amp;
    logic [31:0] t_abs;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        new_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   t_base;
  logic [31:0]   t_new;
  logic [31:0]   diff;
  logic          accept;
  logic          due;
  logic          late;
  logic          drop;
  logic          fire;

  assign pulse_inst_in_ready = (queue_count != FULL);

  always_comb begin
    head   = mem[rd_ptr];
    // Modular difference read as signed: the sign bit alone decides "not yet due", which survives counter wrap.
    diff   = counter - head.t_abs;
    due    = (queue_count != '0) && !diff[31];
    late   = due && (diff != '0);
    drop   = LATE_DROP && due && (diff > 32'(LATE_TOL));
    fire   = due && !drop;
    accept = pulse_inst_in_valid && pulse_inst_in_ready && !flush;
    t_new  = t_base + 32'(pulse_inst_in[11:0]);
    new_entry = '{channel: pulse_inst_in[31:30], freq: pulse_inst_in[29:24],
                  phase: pulse_inst_in[23:18], amp: pulse_inst_in[17:12], t_abs: t_new};
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      queue_count     <= '0;
      t_base          <= '0;
      pulse_out_valid <= 1'b0;
      pulse_channel   <= '0;
      pulse_freq      <= '0;
      pulse_phase     <= '0;
      pulse_amp       <= '0;
      pulse_t_start   <= '0;
      pulse_late      <= 1'b0;
      late_count      <= '0;
    end else if (flush) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      queue_count     <= '0;
      t_base          <= '0;
      pulse_out_valid <= 1'b0;
    end else begin
      pulse_out_valid <= fire;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        t_base <= t_new;
      end
      if (due) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !due)      queue_count <= queue_count + 1'b1;
      else if (!accept && due) queue_count <= queue_count - 1'b1;
      if (fire) begin
        pulse_channel <= head.channel;
        pulse_freq    <= head.freq;
        pulse_phase   <= head.phase;
        pulse_amp     <= head.amp;
        pulse_t_start <= head.t_abs;
        pulse_late    <= late;
      end
      // Dropped heads are always late, so they are counted here as well.
      if (late && late_count != '1) late_count <= late_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_queue.sv
// Bench for pulse_queue: directed vector table, hand sequences, and random traffic against a queue-based model.
module tb_pulse_queue;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned LATE_TOL = 4;
`ifdef PULSE_LATE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] pulse_inst_in;
  logic        pulse_inst_in_valid;
  logic        pulse_inst_in_ready;
  logic        flush;
  logic [31:0] counter;
  logic        pulse_out_valid;
  logic [1:0]  pulse_channel;
  logic [5:0]  pulse_freq;
  logic [5:0]  pulse_phase;
  logic [5:0]  pulse_amp;
  logic [31:0] pulse_t_start;
  logic        pulse_late;
  logic [15:0] late_count;
  logic [$clog2(DEPTH):0] queue_count;

  pulse_queue #(.DEPTH(DEPTH), .LATE_TOL(LATE_TOL)) dut (
    .clk(clk), .rst_n(rst_n),
    .pulse_inst_in(pulse_inst_in), .pulse_inst_in_valid(pulse_inst_in_valid),
    .pulse_inst_in_ready(pulse_inst_in_ready), .flush(flush), .counter(counter),
    .pulse_out_valid(pulse_out_valid), .pulse_channel(pulse_channel),
    .pulse_freq(pulse_freq), .pulse_phase(pulse_phase), .pulse_amp(pulse_amp),
    .pulse_t_start(pulse_t_start), .pulse_late(pulse_late),
    .late_count(late_count), .queue_count(queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending pulses plus the visible output state.
  typedef struct {
    logic [1:0]  ch;
    logic [5:0]  fr;
    logic [5:0]  ph;
    logic [5:0]  am;
    logic [31:0] t;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_tbase = '0;
  logic        m_valid = 1'b0;
  logic        m_late  = 1'b0;
  ent_t        m_out   = '{2'd0, 6'd0, 6'd0, 6'd0, 32'd0};
  int unsigned m_lc    = 0;

  task automatic step();
    int   d;
    bit   acc;
    bit   drop;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_tbase = '0; m_valid = 1'b0; m_late = 1'b0; m_lc = 0;
      m_out = '{2'd0, 6'd0, 6'd0, 6'd0, 32'd0};
    end else if (flush) begin
      mq.delete();
      m_tbase = '0; m_valid = 1'b0;
    end else begin
      acc = pulse_inst_in_valid && (mq.size() < DEPTH);
      m_valid = 1'b0;
      if (mq.size() > 0) begin
        d = $signed(counter - mq[0].t);
        if (d >= 0) begin
          e = mq.pop_front();
          drop = DROP && (d > int'(LATE_TOL));
          if (d > 0 && m_lc < 65535) m_lc++;
          if (!drop) begin
            m_valid = 1'b1;
            m_late  = (d > 0);
            m_out   = e;
          end
        end
      end
      if (acc) begin
        m_tbase = m_tbase + {20'd0, pulse_inst_in[11:0]};
        mq.push_back('{pulse_inst_in[31:30], pulse_inst_in[29:24], pulse_inst_in[23:18],
                       pulse_inst_in[17:12], m_tbase});
      end
    end
    @(posedge clk);
    #1;
    chk("model.valid", pulse_out_valid, m_valid);
    chk("model.count", queue_count, mq.size());
    chk("model.ready", pulse_inst_in_ready, mq.size() != DEPTH);
    chk("model.late_count", late_count, m_lc);
    chk("model.fields", {pulse_channel, pulse_freq, pulse_phase, pulse_amp, pulse_late, pulse_t_start},
        {m_out.ch, m_out.fr, m_out.ph, m_out.am, m_late, m_out.t});
  endtask

  function automatic logic [31:0] mkinst(input logic [11:0] delta);
    return {2'b10, 6'd3, 6'd5, 6'd7, delta};
  endfunction

  typedef struct {
    logic        rst;
    logic        vld;
    logic        fl;
    logic [11:0] delta;
    logic [31:0] cnt;
    logic        ev;
    logic [31:0] et;
    logic        el;
    int          ecount;
    int          elc;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t v(input logic rst, input logic vld, input logic fl, input logic [11:0] delta,
                             input logic [31:0] cnt, input logic ev, input logic [31:0] et,
                             input logic el, input int ecount, input int elc);
    return '{rst, vld, fl, delta, cnt, ev, et, el, ecount, elc};
  endfunction

  initial begin
    int          fire_k;
    logic [31:0] fire_t;
    rst_n = 1'b0; pulse_inst_in = '0; pulse_inst_in_valid = 1'b0; flush = 1'b0; counter = '0;

    //         rst vld fl delta cnt  ev  et   el cnt lc
    vec.push_back(v(0, 0, 0, 0,   0,   0, 0,   0, 0, 0));
    vec.push_back(v(1, 1, 0, 10,  0,   0, 0,   0, 1, 0));
    vec.push_back(v(1, 0, 0, 0,   9,   0, 0,   0, 1, 0));
    vec.push_back(v(1, 0, 0, 0,   10,  1, 10,  0, 0, 0));
    vec.push_back(v(1, 0, 0, 0,   11,  0, 0,   0, 0, 0));
    // deltas 5,0,3 -> stamps 5,5,8
    vec.push_back(v(1, 0, 1, 0,   0,   0, 0,   0, 0, 0));
    vec.push_back(v(1, 1, 0, 5,   0,   0, 0,   0, 1, 0));
    vec.push_back(v(1, 1, 0, 0,   0,   0, 0,   0, 2, 0));
    vec.push_back(v(1, 1, 0, 3,   0,   0, 0,   0, 3, 0));
    vec.push_back(v(1, 0, 0, 0,   5,   1, 5,   0, 2, 0));
    vec.push_back(v(1, 0, 0, 0,   6,   1, 5,   1, 1, 1));
    vec.push_back(v(1, 0, 0, 0,   7,   0, 0,   0, 1, 1));
    vec.push_back(v(1, 0, 0, 0,   8,   1, 8,   0, 0, 1));
    vec.push_back(v(1, 0, 0, 0,   9,   0, 0,   0, 0, 1));
    // flush with 3 queued, head due, instruction valid
    vec.push_back(v(1, 1, 0, 1,   0,   0, 0,   0, 1, 1));
    vec.push_back(v(1, 1, 0, 1,   0,   0, 0,   0, 2, 1));
    vec.push_back(v(1, 1, 0, 1,   0,   0, 0,   0, 3, 1));
    vec.push_back(v(1, 1, 1, 1,   50,  0, 0,   0, 0, 1));
    vec.push_back(v(1, 1, 0, 4,   0,   0, 0,   0, 1, 1));
    vec.push_back(v(1, 0, 0, 0,   4,   1, 4,   0, 0, 1));
    // stamp 100 seen at counter 110
    vec.push_back(v(1, 0, 1, 0,   0,   0, 0,   0, 0, 1));
    vec.push_back(v(1, 1, 0, 100, 110, 0, 0,   0, 1, 1));
    vec.push_back(v(1, 0, 0, 0,   110, !DROP, 100, 1, 0, 2));
    vec.push_back(v(1, 0, 0, 0,   111, 0, 0,   0, 0, 2));
    // reset mid-operation with a due head
    vec.push_back(v(1, 1, 0, 0,   200, 0, 0,   0, 1, 2));
    vec.push_back(v(0, 0, 0, 0,   200, 0, 0,   0, 0, 0));
    vec.push_back(v(1, 0, 0, 0,   200, 0, 0,   0, 0, 0));
    vec.push_back(v(1, 1, 0, 7,   0,   0, 0,   0, 1, 0));
    vec.push_back(v(1, 0, 0, 0,   7,   1, 7,   0, 0, 0));

    foreach (vec[i]) begin
      rst_n = vec[i].rst; pulse_inst_in_valid = vec[i].vld; flush = vec[i].fl;
      pulse_inst_in = mkinst(vec[i].delta); counter = vec[i].cnt;
      step();
      chk($sformatf("vec%0d.valid", i), pulse_out_valid, vec[i].ev);
      chk($sformatf("vec%0d.count", i), queue_count, vec[i].ecount);
      chk($sformatf("vec%0d.late_count", i), late_count, vec[i].elc);
      if (vec[i].ev) begin
        chk($sformatf("vec%0d.t_start", i), pulse_t_start, vec[i].et);
        chk($sformatf("vec%0d.late", i), pulse_late, vec[i].el);
      end
    end

    // Fill to DEPTH with far-future stamps 100,200,...
    pulse_inst_in_valid = 1'b0; flush = 1'b1; counter = '0;
    step();
    flush = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pulse_inst_in_valid = 1'b1; pulse_inst_in = mkinst(12'd100);
      step();
      chk($sformatf("full.ready%0d", i), pulse_inst_in_ready, (i + 1) != int'(DEPTH));
    end
    step();
    chk("full.reject", queue_count, DEPTH);
    counter = 32'd100;
    step();
    chk("full.pop_no_push", queue_count, DEPTH - 1);
    chk("full.pop_fired", pulse_out_valid, 1'b1);
    chk("full.ready_after", pulse_inst_in_ready, 1'b1);

    // Counter wrap: stamp 2 with counter at 0xFFFF_FFFE fires 4 cycles later
    pulse_inst_in_valid = 1'b0; flush = 1'b1; counter = '0;
    step();
    flush = 1'b0; pulse_inst_in_valid = 1'b1; pulse_inst_in = mkinst(12'd2); counter = 32'hFFFF_FFF0;
    step();
    pulse_inst_in_valid = 1'b0;
    fire_k = -1; fire_t = '0;
    for (int k = 0; k < 10; k++) begin
      counter = 32'hFFFF_FFFE + k;
      step();
      if (pulse_out_valid && fire_k < 0) begin
        fire_k = k;
        fire_t = pulse_t_start;
      end
    end
    chk("wrap.fire_cycle", fire_k, 4);
    chk("wrap.t_start", fire_t, 32'd2);

    // Random traffic near counter wrap
    flush = 1'b1;
    step();
    flush = 1'b0; counter = 32'hFFFF_FF80;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      flush = ($urandom_range(0, 79) == 0);
      pulse_inst_in_valid = $urandom_range(0, 1);
      pulse_inst_in = $urandom;
      if ($urandom_range(0, 15) != 0) pulse_inst_in[11:0] = 12'($urandom_range(0, 14));
      case ($urandom_range(0, 9))
        0:       counter = counter;
        1:       counter = counter + $urandom_range(2, 12);
        default: counter = counter + 1;
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_queue.md
# pulse_queue

Timed pulse buffer between the pulse instruction stream and the pulse generation back-end. Accepts 32-bit pulse instructions with a ready/valid handshake. Converts each instruction's relative start delay into an absolute 32-bit timestamp and stores the entry in a FIFO. Releases the head entry as a one-cycle pulse strobe when the global time counter reaches that timestamp.

## Interface

- Parameters:
  - `DEPTH`, 16: FIFO entries; power of two, 2..256.
  - `LATE_TOL`, 4: cycles of lateness tolerated before an entry is dropped; used only with `PULSE_LATE_DROP_EN`.
- Ports:
  - `clk` in 1: single clock for the whole block.
  - `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
  - `pulse_inst_in` in 32: pulse instruction.
  - `pulse_inst_in_valid` in 1: instruction present.
  - `pulse_inst_in_ready` out 1: FIFO can accept an instruction.
  - `flush` in 1: synchronous clear of the queue and the time base.
  - `counter` in 32: global free-running time counter, one increment per cycle.
  - `pulse_out_valid` out 1: one-cycle fire strobe.
  - `pulse_channel` out 2: output channel.
  - `pulse_freq` out 6: frequency index.
  - `pulse_phase` out 6: phase word.
  - `pulse_amp` out 6: amplitude word.
  - `pulse_t_start` out 32: absolute timestamp of the fired entry.
  - `pulse_late` out 1: entry fired after its timestamp.
  - `late_count` out 16: saturating count of late events.
  - `queue_count` out `$clog2(DEPTH)+1`: current occupancy.

## Operation

- Instruction fields:
  - [31:30] channel
  - [29:24] freq
  - [23:18] phase
  - [17:12] amp
  - [11:0] delta, unsigned start delay in cycles
- Accept rule: an instruction is accepted on a rising edge when `pulse_inst_in_valid && pulse_inst_in_ready && !flush`.
- Ready rule: `pulse_inst_in_ready = (queue_count != DEPTH)`. Ready depends on occupancy only. A pop in the same cycle does not make a full queue ready.
- Time base: `t_base` is a 32-bit register.
  - On accept, `t_abs = t_base + delta`, computed modulo 2^32 with wrap allowed. The entry stores the decoded fields plus `t_abs`, and `t_base <= t_abs`.
  - Delays are cumulative: each pulse's start is relative to the previous pulse's start.
- Due test on the head entry: `diff = counter - head.t_abs`, computed modulo 2^32 and interpreted as signed 32-bit.
  - The head is due when `diff >= 0` and the queue is non-empty.
  - The head is late when `diff > 0`.
- Fire: when the head is due, the head is popped on that edge. The output registers load the head's fields and `t_abs`, with `pulse_out_valid = 1` and `pulse_late = (diff > 0)`.
  - At most one fire per cycle.
  - The output fields hold their last value when `pulse_out_valid = 0`.
- Simultaneous accept and fire: both happen; occupancy is unchanged. On an empty queue, the newly accepted entry cannot fire in the same cycle.
- `late_count` increments on every late fire and saturates at 0xFFFF.
- `flush` empties the FIFO, clears `t_base` to 0, and forces `pulse_out_valid = 0`. `late_count` is preserved. Flush wins over a simultaneous accept and a simultaneous fire; the instruction is dropped.

## Timing

- Reset values: all outputs 0 except `pulse_inst_in_ready = 1`. `t_base = 0`, FIFO empty.
- Reset mid-operation discards all queued entries, and any fire pending in that cycle is suppressed.
- Latency:
  - An instruction accepted at edge E is at the head (if the queue was empty) from cycle E+1.
  - If it is already due, `pulse_out_valid` is high in cycle E+2.
- If `counter == t_abs` during cycle C, `pulse_out_valid` is high during cycle C+1 with `pulse_late = 0`.
- Wrap-around: a timestamp of 0x0000_0002 with `counter = 0xFFFF_FFFE` gives `diff = -4` (not due). The entry fires 4 cycles later.

## Configuration

- Macro: `PULSE_LATE_DROP_EN`.
- Defined: a due head with `diff > LATE_TOL` is popped without a fire (`pulse_out_valid` stays 0), and `late_count` increments. Lateness of 1..`LATE_TOL` fires normally with `pulse_late = 1`.
- Undefined: every due head fires; late ones have `pulse_late = 1`. `LATE_TOL` is unused.

## Test plan

- Reset, then hold `counter` at 0 and enqueue delta=10: fire in the cycle after `counter == 10`, with `pulse_t_start = 10` and `pulse_late = 0`.
- Enqueue deltas 5, 0, 3 back-to-back: timestamps 5, 5, 8. Fires on consecutive cycles for 5, 5, then at 8+1; the second 5 fires with `pulse_late = 1`.
- Fill with `DEPTH` entries while `counter` is far behind: `pulse_inst_in_ready` drops to 0 at `queue_count = DEPTH`, and a further valid instruction is not accepted.
- Preload `t_base` near 0xFFFF_FFF0 through chained deltas, then enqueue delta=0x20: `t_abs = 0x10`, and the pulse fires only after `counter` wraps.
- Assert `flush` with `pulse_inst_in_valid = 1` and 3 queued entries: the queue is empty, the instruction is dropped, no fire occurs, and the next delta=4 gives `t_abs = 4`.
- With `PULSE_LATE_DROP_EN` and `LATE_TOL = 4`, enqueue timestamp 100 while `counter = 110`: no fire, `late_count` goes 0→1. Without the macro, it fires with `pulse_late = 1`.
